mode_ctrl: RTL
==============

// Module: mode_ctrl
// PURPOSE
//  Owns processor mode flags E16, E8, M, X; executes REP/SEP/PLP-RTI/XCE/XFE
//  mode updates; publishes registered operand sizes. Sits between decode and
//  register file/ALU. On index-width shrink, runs a truncate handshake so the
//  register file zeroes upper bits of X and Y before the next instruction.
// PARAMETERS
//  ALLOW_32    1  0: native E8 mode caps A and X/Y at SIZE_16 (816-only build)
//  RESET_EMU8  1  1: reset into E16=E8=1 (6502 emu); 0: reset into E16=1,E8=0
// PORTS
//  clk         in   1  system clock
//  reset       in   1  synchronous, active-high
//  op_valid    in   1  mode op request
//  op          in   3  0 NOP,1 REP,2 SEP,3 LOADP,4 XCE,5 XFE,6-7 reserved
//  op_data     in   8  REP/SEP mask or LOADP value; bit5=M, bit4=X
//  op_ready    out  1  op accepted when op_valid & op_ready
//  c_in,v_in   in   1  current carry/overflow flags
//  c_out,v_out out  1  exchanged carry/overflow values
//  cv_we       out  1  1-cycle strobe: ALU flags load c_out/v_out
//  e16,e8,m,x  out  1  current mode flags (registered)
//  size_m      out  3  accumulator size, SIZE_8/16/32
//  size_x      out  3  index size, SIZE_8/16/32
//  trunc_req   out  1  request register file to truncate X,Y to size_x
//  trunc_ack   in   1  register file completed truncation
//  mode_chg    out  1  1-cycle pulse: any size_m/size_x change
// BEHAVIOUR
//  Reset: e16=1, e8=RESET_EMU8, m=1, x=1, size_m=size_x=SIZE_8 (SIZE_16 if
//   e8=0 and m/x=0 — not possible at reset), op_ready=1, trunc_req=0,
//   cv_we=0, mode_chg=0, c_out=v_out=0, state IDLE.
//  Ops (take effect on accept edge; flags and sizes valid next cycle):
//   REP: m&=~d[5], x&=~d[4]. SEP: m|=d[5], x|=d[4]. LOADP: m=d[5], x=d[4].
//   XCE: e16<->C (c_out=old e16, e16=c_in). XFE: e8<->C, e16<->V.
//   NOP/reserved: accepted, no state change, no strobes.
//  cv_we pulses exactly one cycle after accept of XCE/XFE only.
//  Post-update forcing: if new e16=1 and e8=1 then m=1, x=1 (bit4 is B, not X;
//   REP/LOADP cannot clear them). Entering e16=1 from native keeps m, x.
//  Size decode (same cycle as flag register): e16&e8 -> 8/8; e16&~e8 ->
//   m?8:16, x?8:16; ~e16&e8 -> m?8:32, x?8:32; ~e16&~e8 -> m?8:16, x?8:32.
//   ALLOW_32=0: any SIZE_32 result becomes SIZE_16.
//  FSM IDLE: op_ready=1. On accept, if new size_x < old size_x -> TRUNC.
//  FSM TRUNC: op_ready=0, trunc_req=1 from the cycle after accept until the
//   cycle trunc_ack is seen high; then IDLE next cycle (op_ready=1).
//   trunc_ack outside TRUNC ignored. trunc_ack same cycle as entry impossible
//   (req not yet visible); ack may arrive any later cycle, no timeout.
//  Size grow or equal: stay IDLE, no trunc_req; op_ready never drops.
//  size_m shrink needs no handshake (ALU masks A by size_m).
//  mode_chg: 1 cycle after accept iff size_m or size_x differs from old.
//  Back-to-back ops in IDLE: one accepted per cycle, each sees prior result.
//  Reset mid-TRUNC: returns to reset state immediately; trunc_req drops on
//   the reset cycle's edge; pending ack discarded.
// STRUCTURE
//  Shared package reg_mode.vinc: SIZE_8/16/32 constants, ordered numerically
//   SIZE_8 < SIZE_16 < SIZE_32; add MODE_OP_* opcode constants there.
//  Sub-module: reg_mode instance decodes next-state flags to sizes; ALLOW_32
//   clamp and shrink compare live in mode_ctrl.
//  Registers: 4 flags, 2 sizes, 1-bit FSM, cv_we, mode_chg, c_out, v_out.
// TESTING
//  1 Reset, then XCE c_in=0 -> next cycle e16=0,e8=1,m=x=1, c_out=1, cv_we=1,
//    sizes 8/8, mode_chg=0.
//  2 From e16=0,e8=1: REP d=0x30 -> size_m=SIZE_32, size_x=SIZE_32, mode_chg=1;
//    then SEP d=0x10 -> trunc_req=1, op_ready=0 until ack 3 cycles later.
//  3 Native e16=0,e8=0,x=0: XFE c_in=1,v_in=1 -> e8=1,e16=1, m=x=1 forced,
//    size_x 32->8 trunc handshake, c_out=0, v_out=0.
//  4 ALLOW_32=0, e16=0,e8=1: REP 0x30 -> size_m=size_x=SIZE_16.
//  5 Emu8: LOADP d=0x00 -> m=x stay 1, no mode_chg, no trunc_req.
//  6 Reset asserted during TRUNC -> next cycle trunc_req=0, op_ready=1,
//    flags at reset values; later stray trunc_ack has no effect.

Source files
------------

// File: rtl/mode_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mode_ctrl_pkg
//   Shared definitions for the processor mode controller slice: operand size
//   codes, mode-op opcodes, the mode flag bundle and the controller FSM states.
//   Size codes are ordered numerically (SIZE_8 < SIZE_16 < SIZE_32), so a plain
//   magnitude compare on two size codes tells whether a width shrank.
// -----------------------------------------------------------------------------
package mode_ctrl_pkg;

    localparam logic [2:0] SIZE_8  = 3'd1;
    localparam logic [2:0] SIZE_16 = 3'd2;
    localparam logic [2:0] SIZE_32 = 3'd4;

    localparam logic [2:0] MODE_OP_NOP   = 3'd0;
    localparam logic [2:0] MODE_OP_REP   = 3'd1;
    localparam logic [2:0] MODE_OP_SEP   = 3'd2;
    localparam logic [2:0] MODE_OP_LOADP = 3'd3;
    localparam logic [2:0] MODE_OP_XCE   = 3'd4;
    localparam logic [2:0] MODE_OP_XFE   = 3'd5;

    typedef struct packed {
        logic e16;
        logic e8;
        logic m;
        logic x;
    } mode_flags_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_TRUNC = 1'b1
    } state_e;

    // An 816-only build has no 32-bit registers; wide results fall back to 16.
    function automatic logic [2:0] clamp_size(input logic [2:0] size, input bit allow_32);
        return (!allow_32 && size == SIZE_32) ? SIZE_16 : size;
    endfunction

endpackage

// File: rtl/mode_ctrl_if.sv
// -----------------------------------------------------------------------------
// mode_ctrl_if
//   Bundle between decode / register file / ALU and the mode controller.
//   master : decode side (issues mode ops, supplies C/V, acknowledges truncation)
//   slave  : mode_ctrl
//   Signals: op_valid/op/op_data/op_ready  mode-op handshake
//            c_in/v_in, c_out/v_out/cv_we  carry/overflow exchange
//            e16/e8/m/x, size_m/size_x     registered mode flags and sizes
//            trunc_req/trunc_ack           X/Y truncate handshake
//            mode_chg                      1-cycle pulse on any size change
// -----------------------------------------------------------------------------
interface mode_ctrl_if;
    logic       op_valid;
    logic [2:0] op;
    logic [7:0] op_data;
    logic       op_ready;
    logic       c_in;
    logic       v_in;
    logic       c_out;
    logic       v_out;
    logic       cv_we;
    logic       e16;
    logic       e8;
    logic       m;
    logic       x;
    logic [2:0] size_m;
    logic [2:0] size_x;
    logic       trunc_req;
    logic       trunc_ack;
    logic       mode_chg;

    modport master (
        output op_valid, op, op_data, c_in, v_in, trunc_ack,
        input  op_ready, c_out, v_out, cv_we, e16, e8, m, x,
               size_m, size_x, trunc_req, mode_chg
    );

    modport slave (
        input  op_valid, op, op_data, c_in, v_in, trunc_ack,
        output op_ready, c_out, v_out, cv_we, e16, e8, m, x,
               size_m, size_x, trunc_req, mode_chg
    );
endinterface

// File: rtl/mode_ctrl_reg_mode.sv
// -----------------------------------------------------------------------------
// mode_ctrl_reg_mode
//   Pure decode of a mode flag set into accumulator and index operand sizes.
//   Ports: flags  (in)  e16/e8/m/x
//          size_m (out) accumulator size code
//          size_x (out) index size code
//   The result is unclamped; the 816-only cap is applied by the parent.
// -----------------------------------------------------------------------------
module mode_ctrl_reg_mode
    import mode_ctrl_pkg::*;
(
    input  mode_flags_t flags,
    output logic [2:0]  size_m,
    output logic [2:0]  size_x
);
    always_comb begin
        // NOTE: every output gets a default first so no branch can infer a latch.
        size_m = SIZE_8;
        size_x = SIZE_8;
        case ({flags.e16, flags.e8})
            2'b11: begin
                size_m = SIZE_8;
                size_x = SIZE_8;
            end
            2'b10: begin
                size_m = flags.m ? SIZE_8 : SIZE_16;
                size_x = flags.x ? SIZE_8 : SIZE_16;
            end
            2'b01: begin
                size_m = flags.m ? SIZE_8 : SIZE_32;
                size_x = flags.x ? SIZE_8 : SIZE_32;
            end
            default: begin
                // Native E8 with E16 clear: 16-bit accumulator, 32-bit index.
                size_m = flags.m ? SIZE_8 : SIZE_16;
                size_x = flags.x ? SIZE_8 : SIZE_32;
            end
        endcase
    end
endmodule

// File: rtl/mode_ctrl.sv
// -----------------------------------------------------------------------------
// mode_ctrl
//   Owns the E16/E8/M/X mode flags, executes REP/SEP/LOADP/XCE/XFE, publishes
//   registered operand sizes and, when the index width shrinks, holds off new
//   ops until the register file acknowledges truncating X/Y.
//   Ports: clk   system clock
//          reset synchronous, active-high
//          bus   mode_ctrl_if.slave (see interface header)
//   Parameters: ALLOW_32   0 caps every 32-bit size at 16 (816-only build)
//               RESET_EMU8 1 resets into 6502 emulation (E16=E8=1)
// -----------------------------------------------------------------------------
module mode_ctrl
    import mode_ctrl_pkg::*;
#(
    parameter bit ALLOW_32   = 1'b1,
    parameter bit RESET_EMU8 = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    mode_ctrl_if.slave bus
);
    state_e      state;
    state_e      state_nxt;
    mode_flags_t flags;
    mode_flags_t flags_nxt;
    logic [2:0]  size_m_q;
    logic [2:0]  size_x_q;
    logic [2:0]  raw_m;
    logic [2:0]  raw_x;
    logic [2:0]  size_m_nxt;
    logic [2:0]  size_x_nxt;
    logic        c_q;
    logic        v_q;
    logic        c_nxt;
    logic        v_nxt;
    logic        cv_we_q;
    logic        mode_chg_q;
    logic        accept;
    logic        is_xch;
    logic        shrink;

    assign accept = bus.op_valid && (state == ST_IDLE);
    assign is_xch = (bus.op == MODE_OP_XCE) || (bus.op == MODE_OP_XFE);

    // Flags the presented op would produce; committed only on accept.
    always_comb begin
        flags_nxt = flags;
        c_nxt     = c_q;
        v_nxt     = v_q;
        case (bus.op)
            MODE_OP_REP: begin
                flags_nxt.m = flags.m & ~bus.op_data[5];
                flags_nxt.x = flags.x & ~bus.op_data[4];
            end
            MODE_OP_SEP: begin
                flags_nxt.m = flags.m | bus.op_data[5];
                flags_nxt.x = flags.x | bus.op_data[4];
            end
            MODE_OP_LOADP: begin
                flags_nxt.m = bus.op_data[5];
                flags_nxt.x = bus.op_data[4];
            end
            MODE_OP_XCE: begin
                // V is not part of the exchange; hand it back unchanged so the
                // ALU can load both flags on the same strobe.
                flags_nxt.e16 = bus.c_in;
                c_nxt         = flags.e16;
                v_nxt         = bus.v_in;
            end
            MODE_OP_XFE: begin
                flags_nxt.e8  = bus.c_in;
                flags_nxt.e16 = bus.v_in;
                c_nxt         = flags.e8;
                v_nxt         = flags.e16;
            end
            default: ;
        endcase
        // In 6502 emulation bit 4 is B, so M and X are pinned to 1.
        if (flags_nxt.e16 && flags_nxt.e8) begin
            flags_nxt.m = 1'b1;
            flags_nxt.x = 1'b1;
        end
    end

    mode_ctrl_reg_mode u_reg_mode (
        .flags  (flags_nxt),
        .size_m (raw_m),
        .size_x (raw_x)
    );

    assign size_m_nxt = clamp_size(raw_m, ALLOW_32);
    assign size_x_nxt = clamp_size(raw_x, ALLOW_32);
    // Only an index shrink needs the handshake; the ALU masks A by size_m itself.
    assign shrink     = size_x_nxt < size_x_q;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values and the update order inside the block is moot.
        if (reset) begin
            flags      <= '{e16: 1'b1, e8: RESET_EMU8, m: 1'b1, x: 1'b1};
            size_m_q   <= SIZE_8;
            size_x_q   <= SIZE_8;
            c_q        <= 1'b0;
            v_q        <= 1'b0;
            cv_we_q    <= 1'b0;
            mode_chg_q <= 1'b0;
        end else begin
            cv_we_q    <= accept && is_xch;
            mode_chg_q <= accept && ((size_m_nxt != size_m_q) || (size_x_nxt != size_x_q));
            if (accept) begin
                flags    <= flags_nxt;
                size_m_q <= size_m_nxt;
                size_x_q <= size_x_nxt;
                c_q      <= c_nxt;
                v_q      <= v_nxt;
            end
        end
    end

    // FSM: state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state. An ack outside TRUNC falls into IDLE's branch and is ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept && shrink) state_nxt = ST_TRUNC;
            ST_TRUNC: if (bus.trunc_ack)    state_nxt = ST_IDLE;
            default:                        state_nxt = ST_IDLE;
        endcase
    end

    // FSM: outputs.
    always_comb begin
        bus.op_ready  = (state == ST_IDLE);
        bus.trunc_req = (state == ST_TRUNC);
    end

    assign bus.e16      = flags.e16;
    assign bus.e8       = flags.e8;
    assign bus.m        = flags.m;
    assign bus.x        = flags.x;
    assign bus.size_m   = size_m_q;
    assign bus.size_x   = size_x_q;
    assign bus.c_out    = c_q;
    assign bus.v_out    = v_q;
    assign bus.cv_we    = cv_we_q;
    assign bus.mode_chg = mode_chg_q;
endmodule
